// File: rtl/difftest_step_scheduler_pkg.sv
// Shared types and constants for the difftest step scheduler.
package difftest_sched_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam logic [31:0] RES_PASS          = 32'h0;
  localparam logic [31:0] GCPT_CODE_DEFAULT = 32'hff;

endpackage

// File: rtl/difftest_step_scheduler_if.sv
// Check-request / check-result channel between the scheduler (master) and the checker (slave).
interface difftest_step_scheduler_if #(
  parameter int ACC_WIDTH = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic [ACC_WIDTH-1:0] req_steps;
  logic                 rsp_valid;
  logic [31:0]          rsp_result;

  modport master (
    output req_valid,
    output req_steps,
    input  req_ready,
    input  rsp_valid,
    input  rsp_result
  );

  modport slave (
    input  req_valid,
    input  req_steps,
    output req_ready,
    output rsp_valid,
    output rsp_result
  );
endinterface

// File: rtl/difftest_step_scheduler_acc.sv
// Step accumulator: adds accepted steps, clears on batch launch, flags when
// another worst-case step might not fit.
module difftest_step_acc #(
  parameter int STEP_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [STEP_WIDTH-1:0] in_step_i,
  input  logic                  launch_i,
  output logic [ACC_WIDTH-1:0]  acc_o,
  output logic                  stall_full_o
);

  localparam logic [ACC_WIDTH-1:0] FULL_LIM =
    {ACC_WIDTH{1'b1}} - ACC_WIDTH'({STEP_WIDTH{1'b1}});

  logic [ACC_WIDTH-1:0] acc_q, acc_d;

  // The step accepted in the launch cycle belongs to the launched batch.
  always_comb begin
    acc_d = acc_q + ACC_WIDTH'(in_step_i);
    if (launch_i) acc_d = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o        = acc_q;
  assign stall_full_o = (acc_q > FULL_LIM);

endmodule

// File: rtl/difftest_step_scheduler.sv
// Batches DUT commit steps into checker requests and classifies checker results.
// Optional partial-batch flush on idle timeout: define DIFFTEST_BATCH_FLUSH_EN.
//
// state | meaning
// ACCUM | gathering steps, launch on threshold (or idle flush)
// REQ   | request presented, waiting for req_ready
// WAIT  | request accepted, waiting for checker result
// DONE  | run terminated (gcpt exit or mismatch), absorbing
module difftest_step_scheduler
  import difftest_sched_pkg::*;
#(
  parameter int          STEP_WIDTH    = 8,
  parameter int          ACC_WIDTH     = 16,
  parameter int          BATCH_THRESH  = 64,
  parameter int          FLUSH_TIMEOUT = 256,
  parameter logic [31:0] GCPT_CODE     = GCPT_CODE_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [STEP_WIDTH-1:0]     in_step_i,
  output logic                      stall_o,
  difftest_step_scheduler_if.master chk,
  output logic [63:0]               cycle_cnt_o,
  output logic                      done_o,
  output logic                      fail_o,
  output logic                      gcpt_exit_o
);

  sched_state_e         state_q;
  logic                 req_valid_q;
  logic [ACC_WIDTH-1:0] req_steps_q;
  logic                 done_q, fail_q, gcpt_exit_q;
  logic [63:0]          cycle_cnt_q;

  logic [ACC_WIDTH-1:0]  acc;
  logic                  stall_full, stall, launch, flush_hit;
  logic [STEP_WIDTH-1:0] step_acc;
  logic [ACC_WIDTH-1:0]  sum;

  assign stall    = stall_full || (state_q == DONE);
  assign step_acc = stall ? '0 : in_step_i;
  assign sum      = acc + ACC_WIDTH'(step_acc);

`ifdef DIFFTEST_BATCH_FLUSH_EN
  localparam int FLUSH_W = $clog2(FLUSH_TIMEOUT + 1);
  logic [FLUSH_W-1:0] idle_cnt_q;

  assign flush_hit = (state_q == ACCUM) && (step_acc == '0) && (acc != '0) &&
                     (idle_cnt_q == FLUSH_W'(FLUSH_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset)
      idle_cnt_q <= '0;
    else if ((state_q != ACCUM) || launch || (step_acc != '0) || (acc == '0))
      idle_cnt_q <= '0;
    else
      idle_cnt_q <= idle_cnt_q + 1'b1;
  end
`else
  assign flush_hit = 1'b0;
`endif

  assign launch = (state_q == ACCUM) &&
                  ((sum >= ACC_WIDTH'(BATCH_THRESH)) || flush_hit);

  difftest_step_acc #(
    .STEP_WIDTH (STEP_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_acc (
    .clock        (clock),
    .reset        (reset),
    .in_step_i    (step_acc),
    .launch_i     (launch),
    .acc_o        (acc),
    .stall_full_o (stall_full)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ACCUM;
      req_valid_q <= 1'b0;
      req_steps_q <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      gcpt_exit_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (launch) begin
            state_q     <= REQ;
            req_valid_q <= 1'b1;
            req_steps_q <= sum;
          end
        end
        REQ: begin
          if (chk.req_ready) begin
            state_q     <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (chk.rsp_valid) begin
            if (chk.rsp_result == RES_PASS) begin
              state_q <= ACCUM;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              if (chk.rsp_result == GCPT_CODE) gcpt_exit_q <= 1'b1;
              else                             fail_q      <= 1'b1;
            end
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= ACCUM;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) cycle_cnt_q <= '0;
    else        cycle_cnt_q <= cycle_cnt_q + 64'd1;
  end

  assign chk.req_valid = req_valid_q;
  assign chk.req_steps = req_steps_q;
  assign stall_o       = stall;
  assign cycle_cnt_o   = cycle_cnt_q;
  assign done_o        = done_q;
  assign fail_o        = fail_q;
  assign gcpt_exit_o   = gcpt_exit_q;

endmodule

// File: tb/tb_difftest_step_scheduler.sv
// Directed bench for difftest_step_scheduler with hand-computed expectations.
module tb_difftest_step_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_step;
  logic        stall;
  logic [63:0] cycle_cnt;
  logic        done, fail, gcpt;
  int          total = 0;
  int          bad   = 0;

  difftest_step_scheduler_if #(.ACC_WIDTH(16)) bus ();

  difftest_step_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .in_step_i   (in_step),
    .stall_o     (stall),
    .chk         (bus.master),
    .cycle_cnt_o (cycle_cnt),
    .done_o      (done),
    .fail_o      (fail),
    .gcpt_exit_o (gcpt)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset          = 1'b0;
    in_step        = 8'd0;
    bus.req_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_result = 32'h0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; in_step = 8'd0; bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0; bus.rsp_result = 32'h0;
    tick(); tick();
    total++;
    if ({bus.req_valid, stall, done, fail, gcpt} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs: got %b expected 00000", {bus.req_valid, stall, done, fail, gcpt});
    end
    total++;
    if (bus.req_steps !== 16'd0) begin bad++; $display("FAIL reset_req_steps: got %0d expected 0", bus.req_steps); end
    total++;
    if (cycle_cnt !== 64'd0) begin bad++; $display("FAIL reset_cycle_cnt: got %0d expected 0", cycle_cnt); end
    reset = 1'b1;
    tick();
    total++;
    if (cycle_cnt !== 64'd1) begin bad++; $display("FAIL cycle_cnt_first: got %0d expected 1", cycle_cnt); end
    tick(); tick();
    total++;
    if (cycle_cnt !== 64'd3) begin bad++; $display("FAIL cycle_cnt_run: got %0d expected 3", cycle_cnt); end
  endtask

  task automatic test_batch;
    int early = 0;
    int n;
    do_reset();
    in_step = 8'd8; bus.req_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.req_valid) early++;
    end
    total++;
    if (early != 0) begin bad++; $display("FAIL batch_early: got %0d early cycles expected 0", early); end
    tick();
    total++;
    if (bus.req_valid !== 1'b1 || bus.req_steps !== 16'd64) begin
      bad++; $display("FAIL batch_first: got valid=%b steps=%0d expected valid=1 steps=64", bus.req_valid, bus.req_steps);
    end
    for (int b = 0; b < 3; b++) begin
      tick();
      total++;
      if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL batch_handshake: got valid=%b expected 0", bus.req_valid); end
      tick(); tick();
      bus.rsp_valid = 1'b1; bus.rsp_result = 32'h0;
      tick();
      bus.rsp_valid = 1'b0;
      n = 0;
      while (!bus.req_valid && n < 20) begin tick(); n++; end
      total++;
      if (n != 4 || bus.req_steps !== 16'd64) begin
        bad++; $display("FAIL batch_steady: got gap=%0d steps=%0d expected gap=4 steps=64", n, bus.req_steps);
      end
    end
    total++;
    if (done !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL batch_flags: got done=%b fail=%b expected 0 0", done, fail); end
    in_step = 8'd0;
  endtask

  task automatic test_backpressure;
    int acc_exp = 0;
    int stall_err = 0;
    int hold_err = 0;
    logic accepted;
    do_reset();
    in_step = 8'd60;
    tick();
    total++;
    if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL bp_below_thresh: got valid=%b expected 0", bus.req_valid); end
    in_step = 8'd10;
    tick();
    total++;
    if (bus.req_valid !== 1'b1 || bus.req_steps !== 16'd70) begin
      bad++; $display("FAIL bp_launch: got valid=%b steps=%0d expected valid=1 steps=70", bus.req_valid, bus.req_steps);
    end
    in_step = 8'd255;
    for (int i = 0; i < 1000; i++) begin
      if (stall !== (acc_exp > 65280)) stall_err++;
      if (bus.req_valid !== 1'b1 || bus.req_steps !== 16'd70) hold_err++;
      accepted = !(acc_exp > 65280);
      tick();
      if (accepted) acc_exp += 255;
    end
    total++;
    if (stall_err != 0) begin bad++; $display("FAIL bp_stall_track: got %0d wrong cycles expected 0", stall_err); end
    total++;
    if (hold_err != 0) begin bad++; $display("FAIL bp_req_hold: got %0d unstable cycles expected 0", hold_err); end
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL bp_stall_final: got %b expected 1", stall); end
    bus.req_ready = 1'b1; in_step = 8'd0;
    tick();
    total++;
    if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got valid=%b expected 0", bus.req_valid); end
  endtask

  task automatic test_gcpt;
    do_reset();
    in_step = 8'd64;
    tick();
    total++;
    if (bus.req_valid !== 1'b1 || bus.req_steps !== 16'd64) begin
      bad++; $display("FAIL gcpt_launch: got valid=%b steps=%0d expected valid=1 steps=64", bus.req_valid, bus.req_steps);
    end
    in_step = 8'd0; bus.req_ready = 1'b1;
    bus.rsp_valid = 1'b1; bus.rsp_result = 32'hff;
    tick();
    bus.rsp_valid = 1'b0;
    total++;
    if (bus.req_valid !== 1'b0 || gcpt !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL gcpt_same_cycle_rsp: got valid=%b gcpt=%b done=%b expected 0 0 0", bus.req_valid, gcpt, done);
    end
    tick();
    bus.rsp_valid = 1'b1; bus.rsp_result = 32'hff;
    tick();
    bus.rsp_valid = 1'b0;
    total++;
    if ({gcpt, done, fail, stall} !== 4'b1101) begin
      bad++; $display("FAIL gcpt_exit: got gcpt/done/fail/stall=%b expected 1101", {gcpt, done, fail, stall});
    end
    bus.rsp_valid = 1'b1; bus.rsp_result = 32'h5;
    tick();
    bus.rsp_valid = 1'b0;
    total++;
    if (fail !== 1'b0 || gcpt !== 1'b1) begin bad++; $display("FAIL gcpt_late_rsp: got fail=%b gcpt=%b expected 0 1", fail, gcpt); end
    in_step = 8'd50;
    tick(); tick(); tick();
    total++;
    if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL gcpt_no_req: got valid=%b expected 0", bus.req_valid); end
    in_step = 8'd0;
  endtask

  task automatic test_fail;
    int cnt = 0;
    logic [63:0] c0;
    do_reset();
    bus.rsp_valid = 1'b1; bus.rsp_result = 32'h3;
    tick();
    bus.rsp_valid = 1'b0;
    total++;
    if (fail !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL fail_rsp_in_accum: got fail=%b done=%b expected 0 0", fail, done); end
    in_step = 8'd100;
    tick();
    total++;
    if (bus.req_steps !== 16'd100) begin bad++; $display("FAIL fail_launch: got steps=%0d expected 100", bus.req_steps); end
    in_step = 8'd0; bus.rsp_valid = 1'b1; bus.rsp_result = 32'h3;
    tick();
    bus.rsp_valid = 1'b0;
    total++;
    if (fail !== 1'b0 || bus.req_valid !== 1'b1) begin
      bad++; $display("FAIL fail_rsp_in_req: got fail=%b valid=%b expected 0 1", fail, bus.req_valid);
    end
    bus.req_ready = 1'b1;
    tick();
    bus.rsp_valid = 1'b1; bus.rsp_result = 32'h3;
    tick();
    bus.rsp_valid = 1'b0;
    total++;
    if ({fail, done, gcpt} !== 3'b110) begin bad++; $display("FAIL fail_flags: got fail/done/gcpt=%b expected 110", {fail, done, gcpt}); end
    c0 = cycle_cnt;
    in_step = 8'd10;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.req_valid) cnt++;
    end
    total++;
    if (cnt != 0) begin bad++; $display("FAIL fail_no_req: got %0d req cycles expected 0", cnt); end
    total++;
    if (cycle_cnt !== c0 + 64'd100) begin bad++; $display("FAIL fail_cycle_cnt: got %0d expected %0d", cycle_cnt, c0 + 64'd100); end
    in_step = 8'd0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    in_step = 8'd64;
    tick();
    in_step = 8'd200; bus.req_ready = 1'b1;
    tick();
    in_step = 8'd0;
    tick();
    bus.rsp_valid = 1'b1; bus.rsp_result = 32'h0;
    tick();
    bus.rsp_valid = 1'b0;
    total++;
    if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap: got valid=%b expected 0", bus.req_valid); end
    tick();
    total++;
    if (bus.req_valid !== 1'b1 || bus.req_steps !== 16'd200) begin
      bad++; $display("FAIL b2b_reissue: got valid=%b steps=%0d expected valid=1 steps=200", bus.req_valid, bus.req_steps);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    in_step = 8'd64;
    tick();
    in_step = 8'd0; bus.req_ready = 1'b1;
    tick(); tick();
    total++;
    if (cycle_cnt !== 64'd3) begin bad++; $display("FAIL mid_cycle_cnt: got %0d expected 3", cycle_cnt); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    total++;
    if ({bus.req_valid, done, fail, gcpt, stall} !== 5'b0 || cycle_cnt !== 64'd0) begin
      bad++; $display("FAIL mid_reset: got outs=%b cnt=%0d expected 00000 0", {bus.req_valid, done, fail, gcpt, stall}, cycle_cnt);
    end
    bus.rsp_valid = 1'b1; bus.rsp_result = 32'h3;
    tick();
    bus.rsp_valid = 1'b0;
    total++;
    if (fail !== 1'b0) begin bad++; $display("FAIL mid_stale_rsp: got fail=%b expected 0", fail); end
    in_step = 8'd64;
    tick();
    total++;
    if (bus.req_valid !== 1'b1 || bus.req_steps !== 16'd64) begin
      bad++; $display("FAIL mid_relaunch: got valid=%b steps=%0d expected valid=1 steps=64", bus.req_valid, bus.req_steps);
    end
    in_step = 8'd0;
  endtask

  task automatic test_flush;
    int n = 0;
    do_reset();
    in_step = 8'd5;
    tick();
    in_step = 8'd0;
    while (!bus.req_valid && n < 300) begin tick(); n++; end
`ifdef DIFFTEST_BATCH_FLUSH_EN
    total++;
    if (n != 256 || bus.req_steps !== 16'd5) begin
      bad++; $display("FAIL flush_partial: got delay=%0d steps=%0d expected delay=256 steps=5", n, bus.req_steps);
    end
`else
    total++;
    if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL flush_disabled: got valid=%b after %0d cycles expected 0", bus.req_valid, n); end
`endif
  endtask

  initial begin
    test_reset();
    test_batch();
    test_backpressure();
    test_gcpt();
    test_fail();
    test_back_to_back();
    test_reset_mid();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
